regfile_dump_reader: RTL

- Read-side companion to the 32 x 32-bit register file; the register file's write path is the write-enabled register array, and this block is the reader.
- On a start pulse it walks a range of register indices through one register-file read port, capturing each word.
- Each captured word is presented on a valid/ready output stream tagged with its index, for the debug/trace path and checkpoint test harness.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_idx_counter.sv | 32 +++
 rtl/regfile_dump_reader.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump reader's state encoding.
// The register file, its decoders and the dump reader all import this package.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  // Increment that wraps at NUM_REGS, so the count stays correct if NUM_REGS is not a power of two.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] i);
    return (i == ADDR_W'(NUM_REGS - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_idx_counter.sv
// Loadable register-index counter that wraps modulo NUM_REGS.
// It also latches the end index at load time and flags when the count reaches it.
module regfile_idx_counter
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] idx,
  output logic              is_last
);

  logic [ADDR_W-1:0] last_q;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      idx    <= '0;
      last_q <= '0;
    end else if (load) begin
      idx    <= first;
      last_q <= last;
    end else if (inc) begin
      idx    <= next_idx(idx);
    end
  end

  assign is_last = (idx == last_q);

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a range of register indices through one read port and emits each word on a valid/ready stream.
// Each word takes two cycles (READ then HOLD). The stream holds its word while out_ready is low.
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_start,
  input  logic              ctrl_abort,
  input  logic [ADDR_W-1:0] ctrl_first,
  input  logic [ADDR_W-1:0] ctrl_last,
  output logic [ADDR_W-1:0] ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic              is_last;
  logic              cnt_load;
  logic              cnt_inc;

  assign cnt_load = (state == IDLE) && ctrl_start;
  assign cnt_inc  = (state == HOLD) && out_ready && !out_last && !ctrl_abort;

  // The counter register drives the read port directly, so the address stays stable for the whole READ cycle.
  regfile_idx_counter u_idx (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .load       (cnt_load),
    .inc        (cnt_inc),
    .first      (ctrl_first),
    .last       (ctrl_last),
    .idx        (idx),
    .is_last    (is_last)
  );

  assign ctrl_readReg = idx;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ctrl_abort && state != IDLE) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ctrl_start) begin
              state <= READ;
              busy  <= 1'b1;
            end
          end
          READ: begin
            out_data  <= data_readReg;
            out_index <= idx;
            out_valid <= 1'b1;
            out_last  <= is_last;
            state     <= HOLD;
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (out_last) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= READ;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
